// File: rtl/branch_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_stack_ctrl
// Function : Branch checkpoint controller for maptable recovery. Holds one
//            maptable snapshot per in-flight branch in an age-ordered
//            circular buffer. Keeps the stored valid bits current from the
//            CDB. On a mispredict it squashes the branch and everything
//            younger, then pulses the restored map state for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module branch_stack_ctrl #(
    parameter int DEPTH    = 4,
    parameter int LREG_NUM = 32,
    parameter int PREG_W   = 6,
    localparam int TAG_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int LREG_W  = $clog2(LREG_NUM),
    localparam int MT_W    = LREG_NUM * (PREG_W + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc_valid,
    input  logic [MT_W-1:0]       alloc_state,
    output logic                  alloc_ready,
    output logic [TAG_W-1:0]      alloc_tag,
    input  logic                  resolve_valid,
    input  logic [TAG_W-1:0]      resolve_tag,
    input  logic                  resolve_mispredict,
    input  logic [2:0]            cdb_valid,
    input  logic [3*LREG_W-1:0]   cdb_lreg,
    input  logic [3*PREG_W-1:0]   cdb_preg,
    output logic                  recover_valid,
    output logic [MT_W-1:0]       recover_state,
    output logic [DEPTH-1:0]      squash_mask,
    output logic [CNT_W-1:0]      count
);

    localparam int ENT_W = PREG_W + 1;

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_RECOVER = 1'b1;

    // Sets the valid bit of every map entry whose lreg and preg match a
    // valid CDB lane; entries with a different preg are left untouched.
    function automatic logic [MT_W-1:0] f_cdb_apply(
        input logic [MT_W-1:0]     state,
        input logic [2:0]          lane_valid,
        input logic [3*LREG_W-1:0] lane_lreg,
        input logic [3*PREG_W-1:0] lane_preg
    );
        logic [MT_W-1:0] res;
        res = state;
        for (int j = 0; j < LREG_NUM; j++) begin
            for (int k = 0; k < 3; k++) begin
                if (lane_valid[k] &&
                    (lane_lreg[k*LREG_W +: LREG_W] == LREG_W'(j)) &&
                    (res[j*ENT_W +: PREG_W] == lane_preg[k*PREG_W +: PREG_W])) begin
                    res[j*ENT_W + PREG_W] = 1'b1;
                end
            end
        end
        return res;
    endfunction

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_done;
    logic [MT_W-1:0]  r_snap [DEPTH];

    logic             r_recover_valid;
    logic [MT_W-1:0]  r_recover_state;
    logic [DEPTH-1:0] r_squash_mask;

    logic [DEPTH-1:0] w_live;
    logic [MT_W-1:0]  w_snap_upd [DEPTH];
    logic [DEPTH-1:0] w_squash;
    logic [MT_W-1:0]  w_alloc_upd;
    logic [MT_W-1:0]  w_recover_upd;

    logic             w_run;
    logic             w_mispredict_in;
    logic             w_mispredict;
    logic             w_correct;
    logic             w_alloc;
    logic             w_retire;
    logic [CNT_W-1:0] w_keep;
    logic [CNT_W-1:0] w_killed;

    assign w_run           = (r_state == c_ST_RUN);
    assign w_mispredict_in = resolve_valid & resolve_mispredict;
    // Resolves only count in RUN and only against a live tag.
    assign w_mispredict    = w_run & w_mispredict_in & w_live[resolve_tag];
    assign w_correct       = w_run & resolve_valid & ~resolve_mispredict & w_live[resolve_tag];

    // Raw mispredict input blocks alloc even before liveness is known.
    assign alloc_ready = w_run & (r_count < CNT_W'(DEPTH)) & ~w_mispredict_in;
    assign w_alloc     = alloc_valid & alloc_ready;
    assign w_retire    = w_run & (r_count != '0) & r_done[r_head] & ~w_mispredict;

    // Entries older than the mispredicted one survive; the rest are killed.
    assign w_keep   = CNT_W'(TAG_W'(resolve_tag - r_head));
    assign w_killed = r_count - w_keep;

    assign w_alloc_upd   = f_cdb_apply(alloc_state, cdb_valid, cdb_lreg, cdb_preg);
    assign w_recover_upd = f_cdb_apply(r_snap[resolve_tag], cdb_valid, cdb_lreg, cdb_preg);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [TAG_W-1:0] w_age;
        logic [TAG_W-1:0] w_dist;
        // Age relative to head decides liveness; count separates full/empty.
        assign w_age          = TAG_W'(gi) - r_head;
        assign w_live[gi]     = (CNT_W'(w_age) < r_count);
        // Distance from the mispredicted tag, walking toward the tail.
        assign w_dist         = TAG_W'(gi) - resolve_tag;
        assign w_squash[gi]   = (CNT_W'(w_dist) < w_killed);
        assign w_snap_upd[gi] = f_cdb_apply(r_snap[gi], cdb_valid, cdb_lreg, cdb_preg);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a live mispredict enters RECOVER for exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN:     if (w_mispredict) w_state_nxt = c_ST_RECOVER;
            c_ST_RECOVER: w_state_nxt = c_ST_RUN;
            default:      w_state_nxt = c_ST_RUN;
        endcase
    end

    // Head, tail and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_retire) begin
                r_head <= r_head + TAG_W'(1);
            end
            if (w_mispredict) begin
                r_tail  <= resolve_tag;
                r_count <= w_keep;
            end else begin
                if (w_alloc) begin
                    r_tail <= r_tail + TAG_W'(1);
                end
                case ({w_alloc, w_retire})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Per-entry done bits: cleared on alloc or retire, set by a correct resolve.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc && (r_tail == TAG_W'(i))) begin
                    r_done[i] <= 1'b0;
                end else if (w_retire && (r_head == TAG_W'(i))) begin
                    r_done[i] <= 1'b0;
                end else if (w_correct && (resolve_tag == TAG_W'(i))) begin
                    r_done[i] <= 1'b1;
                end
            end
        end
    end

    // Snapshot storage: capture on alloc, keep live entries current from the CDB.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc && (r_tail == TAG_W'(i))) begin
                    r_snap[i] <= w_alloc_upd;
                end else if (w_live[i]) begin
                    r_snap[i] <= w_snap_upd[i];
                end
            end
        end
    end

    // Registered recovery pulse; payload holds until the next mispredict.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_recover_valid <= 1'b0;
            r_recover_state <= '0;
            r_squash_mask   <= '0;
        end else begin
            r_recover_valid <= w_mispredict;
            if (w_mispredict) begin
                r_recover_state <= w_recover_upd;
                r_squash_mask   <= w_squash;
            end
        end
    end

    assign alloc_tag     = r_tail;
    assign count         = r_count;
    assign recover_valid = r_recover_valid;
    assign recover_state = r_recover_state;
    assign squash_mask   = r_squash_mask;

endmodule
`default_nettype wire

// File: tb/tb_branch_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_stack_ctrl
// Function : Directed self-checking bench for branch_stack_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_stack_ctrl;

    localparam int DEPTH    = 4;
    localparam int LREG_NUM = 32;
    localparam int PREG_W   = 6;
    localparam int TAG_W    = 2;
    localparam int CNT_W    = 3;
    localparam int LREG_W   = 5;
    localparam int ENT_W    = PREG_W + 1;
    localparam int MT_W     = LREG_NUM * ENT_W;

    logic                clock = 1'b0;
    logic                reset;
    logic                alloc_valid;
    logic [MT_W-1:0]     alloc_state;
    logic                alloc_ready;
    logic [TAG_W-1:0]    alloc_tag;
    logic                resolve_valid;
    logic [TAG_W-1:0]    resolve_tag;
    logic                resolve_mispredict;
    logic [2:0]          cdb_valid;
    logic [3*LREG_W-1:0] cdb_lreg;
    logic [3*PREG_W-1:0] cdb_preg;
    logic                recover_valid;
    logic [MT_W-1:0]     recover_state;
    logic [DEPTH-1:0]    squash_mask;
    logic [CNT_W-1:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [MT_W-1:0] S [0:5];
    logic [MT_W-1:0] C;
    logic [MT_W-1:0] exp_state;

    branch_stack_ctrl #(
        .DEPTH    (DEPTH),
        .LREG_NUM (LREG_NUM),
        .PREG_W   (PREG_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_valid        (alloc_valid),
        .alloc_state        (alloc_state),
        .alloc_ready        (alloc_ready),
        .alloc_tag          (alloc_tag),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .cdb_valid          (cdb_valid),
        .cdb_lreg           (cdb_lreg),
        .cdb_preg           (cdb_preg),
        .recover_valid      (recover_valid),
        .recover_state      (recover_state),
        .squash_mask        (squash_mask),
        .count              (count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MT_W-1:0] mk(input int seed);
        logic [MT_W-1:0] res;
        for (int j = 0; j < LREG_NUM; j++) begin
            res[j*ENT_W +: ENT_W] = {1'b0, PREG_W'((seed * 13 + j * 5) & 63)};
        end
        return res;
    endfunction

    function automatic logic [MT_W-1:0] set_ent(input logic [MT_W-1:0] s, input int lreg,
                                                input logic v, input int preg);
        logic [MT_W-1:0] res;
        res = s;
        res[lreg*ENT_W +: ENT_W] = {v, PREG_W'(preg)};
        return res;
    endfunction

    task automatic idle();
        alloc_valid        = 1'b0;
        alloc_state        = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_mispredict = 1'b0;
        cdb_valid          = '0;
        cdb_lreg           = '0;
        cdb_preg           = '0;
    endtask

    task automatic set_lane(input int k, input int lreg, input int preg);
        cdb_valid[k]                  = 1'b1;
        cdb_lreg[k*LREG_W +: LREG_W] = LREG_W'(lreg);
        cdb_preg[k*PREG_W +: PREG_W] = PREG_W'(preg);
    endtask

    task automatic mispredict(input int tag);
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        resolve_tag        = TAG_W'(tag);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        idle();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Allocates S[0..n-1]; returns at the negedge after the last accept, idle.
    task automatic alloc_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            idle();
            alloc_valid = 1'b1;
            alloc_state = S[k];
        end
        @(negedge clock);
        idle();
    endtask

    initial begin
        for (int i = 0; i < 6; i++) S[i] = mk(i + 1);
        C = '0;
        C = set_ent(C, 5, 1'b0, 40);
        C = set_ent(C, 6, 1'b0, 41);

        idle();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_alloc_ready", 256'(alloc_ready), 256'(1));
        chk("rst_alloc_tag", 256'(alloc_tag), 256'(0));
        chk("rst_recover_valid", 256'(recover_valid), 256'(0));
        chk("rst_recover_state", 256'(recover_state), 256'(0));
        chk("rst_squash_mask", 256'(squash_mask), 256'(0));
        reset = 1'b1;

        // Fill the buffer with four checkpoints.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("fill_count", 256'(count), 256'(k));
            alloc_valid = 1'b1;
            alloc_state = S[k];
            #1;
            chk("fill_alloc_tag", 256'(alloc_tag), 256'(k));
            chk("fill_alloc_ready", 256'(alloc_ready), 256'(1));
        end
        @(negedge clock);
        idle();
        #1;
        chk("full_count", 256'(count), 256'(4));
        chk("full_alloc_ready", 256'(alloc_ready), 256'(0));

        // Correct resolves of tags 1 then 0 retire two entries in order.
        resolve_valid = 1'b1;
        resolve_tag   = 2'd1;
        @(negedge clock);
        chk("res_count_a", 256'(count), 256'(4));
        resolve_tag   = 2'd0;
        @(negedge clock);
        idle();
        chk("res_count_b", 256'(count), 256'(4));
        @(negedge clock);
        chk("res_count_c", 256'(count), 256'(3));
        #1;
        chk("res_ready_reopen", 256'(alloc_ready), 256'(1));
        @(negedge clock);
        chk("res_count_d", 256'(count), 256'(2));
        chk("res_tail", 256'(alloc_tag), 256'(0));

        // head = 2: mispredict tag 3 kills only entry 3.
        mispredict(3);
        #1;
        chk("mp3_ready_n", 256'(alloc_ready), 256'(0));
        @(negedge clock);
        idle();
        chk("mp3_recover_valid", 256'(recover_valid), 256'(1));
        chk("mp3_recover_state", 256'(recover_state), 256'(S[3]));
        chk("mp3_squash", 256'(squash_mask), 256'(4'b1000));
        chk("mp3_count", 256'(count), 256'(1));
        chk("mp3_tail", 256'(alloc_tag), 256'(3));
        #1;
        chk("mp3_ready_n1", 256'(alloc_ready), 256'(0));
        @(negedge clock);
        chk("mp3_pulse_end", 256'(recover_valid), 256'(0));
        alloc_valid = 1'b1;
        alloc_state = S[4];
        #1;
        chk("wrap_ready", 256'(alloc_ready), 256'(1));
        chk("wrap_tag3", 256'(alloc_tag), 256'(3));
        @(negedge clock);
        alloc_state = S[5];
        #1;
        chk("wrap_tag0", 256'(alloc_tag), 256'(0));
        @(negedge clock);
        idle();
        chk("wrap_count", 256'(count), 256'(3));
        mispredict(0);
        @(negedge clock);
        idle();
        chk("wrap_mp_state", 256'(recover_state), 256'(S[5]));
        chk("wrap_mp_squash", 256'(squash_mask), 256'(4'b0001));
        chk("wrap_mp_count", 256'(count), 256'(2));
        chk("wrap_mp_tail", 256'(alloc_tag), 256'(0));

        // Full buffer, head = 0: mispredict tag 1 while alloc is requested.
        pulse_reset();
        alloc_n(4);
        mispredict(1);
        alloc_valid = 1'b1;
        alloc_state = S[5];
        #1;
        chk("mp1_ready_n", 256'(alloc_ready), 256'(0));
        @(negedge clock);
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        chk("mp1_recover_valid", 256'(recover_valid), 256'(1));
        chk("mp1_recover_state", 256'(recover_state), 256'(S[1]));
        chk("mp1_squash", 256'(squash_mask), 256'(4'b1110));
        chk("mp1_count", 256'(count), 256'(1));
        chk("mp1_tail", 256'(alloc_tag), 256'(1));
        #1;
        chk("mp1_ready_n1", 256'(alloc_ready), 256'(0));
        @(negedge clock);
        idle();
        chk("mp1_pulse_end", 256'(recover_valid), 256'(0));
        chk("mp1_no_alloc_count", 256'(count), 256'(1));
        chk("mp1_no_alloc_tail", 256'(alloc_tag), 256'(1));
        #1;
        chk("mp1_ready_n2", 256'(alloc_ready), 256'(1));
        mispredict(0);
        alloc_valid = 1'b1;
        alloc_state = S[5];
        #1;
        chk("mp0_ready", 256'(alloc_ready), 256'(0));
        @(negedge clock);
        idle();
        chk("mp0_count", 256'(count), 256'(0));
        chk("mp0_tail", 256'(alloc_tag), 256'(0));
        chk("mp0_state", 256'(recover_state), 256'(S[0]));
        chk("mp0_squash", 256'(squash_mask), 256'(4'b0001));
        mispredict(0);
        @(negedge clock);
        idle();
        mispredict(2);
        @(negedge clock);
        idle();
        chk("dead_tag_ignored", 256'(recover_valid), 256'(0));
        chk("dead_tag_count", 256'(count), 256'(0));

        // CDB wakeup of stored snapshots.
        pulse_reset();
        alloc_valid = 1'b1;
        alloc_state = C;
        set_lane(0, 6, 41);
        #1;
        chk("cdb_tag0", 256'(alloc_tag), 256'(0));
        @(negedge clock);
        idle();
        set_lane(1, 5, 41);
        set_lane(2, 5, 40);
        @(negedge clock);
        idle();
        alloc_valid = 1'b1;
        alloc_state = C;
        set_lane(1, 5, 41);
        #1;
        chk("cdb_tag1", 256'(alloc_tag), 256'(1));
        @(negedge clock);
        idle();
        mispredict(1);
        @(negedge clock);
        idle();
        chk("cdb_nomatch_valid", 256'(recover_valid), 256'(1));
        chk("cdb_nomatch_lreg5", 256'(recover_state[5*ENT_W +: ENT_W]), 256'({1'b0, 6'd40}));
        chk("cdb_nomatch_state", 256'(recover_state), 256'(C));
        chk("cdb_nomatch_count", 256'(count), 256'(1));
        @(negedge clock);
        chk("cdb_pulse_end", 256'(recover_valid), 256'(0));
        mispredict(0);
        set_lane(0, 0, 0);
        @(negedge clock);
        idle();
        exp_state = set_ent(C, 5, 1'b1, 40);
        exp_state = set_ent(exp_state, 6, 1'b1, 41);
        exp_state = set_ent(exp_state, 0, 1'b1, 0);
        chk("cdb_match_lreg5", 256'(recover_state[5*ENT_W +: ENT_W]), 256'({1'b1, 6'd40}));
        chk("cdb_match_state", 256'(recover_state), 256'(exp_state));
        chk("cdb_match_squash", 256'(squash_mask), 256'(4'b0001));
        chk("cdb_match_count", 256'(count), 256'(0));

        // Reset asserted while the recovery pulse is high.
        pulse_reset();
        alloc_n(2);
        mispredict(0);
        @(negedge clock);
        idle();
        chk("rr_pulse", 256'(recover_valid), 256'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("rr_valid_drop", 256'(recover_valid), 256'(0));
        chk("rr_count", 256'(count), 256'(0));
        chk("rr_state", 256'(recover_state), 256'(0));
        chk("rr_squash", 256'(squash_mask), 256'(0));
        chk("rr_ready", 256'(alloc_ready), 256'(1));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_stack_ctrl.md
# branch_stack_ctrl

Checkpoint controller for maptable recovery. It captures a maptable snapshot for every dispatched branch, tracks checkpoints in age order in a circular buffer of `DEPTH` entries, and keeps stored valid bits current from the CDB. On a mispredict it squashes the mispredicted checkpoint and all younger ones, then drives a one-cycle recovery pulse carrying the restored map state into the maptable's recovery port.

## Interface
- `DEPTH`, 4: checkpoint entries; power of 2, ≥2
- `LREG_NUM`, 32: logical registers
- `PREG_W`, 6: physical register index width
- Derived: `TAG_W = $clog2(DEPTH)`, `CNT_W = $clog2(DEPTH+1)`, `MT_W = LREG_NUM*(PREG_W+1)`; entry i occupies bits `[i*(PREG_W+1) +: PREG_W+1]` as {valid, preg}

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `alloc_valid`  in  1  branch dispatched, requests a checkpoint
- `alloc_state`  in  MT_W  maptable state to snapshot
- `alloc_ready`  out  1  checkpoint can be accepted this cycle
- `alloc_tag`  out  TAG_W  tag granted to an accepted alloc (= tail)
- `resolve_valid`  in  1  branch resolved
- `resolve_tag`  in  TAG_W  tag of resolved branch
- `resolve_mispredict`  in  1  qualifies resolve: 1 = mispredicted
- `cdb_valid`  in  3  CDB lane valid
- `cdb_lreg`  in  3×$clog2(LREG_NUM)  completing logical reg per lane
- `cdb_preg`  in  3×PREG_W  completing physical reg per lane
- `recover_valid`  out  1  one-cycle recovery pulse (registered)
- `recover_state`  out  MT_W  restored map state, valid when `recover_valid`
- `squash_mask`  out  DEPTH  tags killed by the recovery, valid when `recover_valid`
- `count`  out  CNT_W  live checkpoints

## Operation
- Storage: `DEPTH` snapshots; `head` (oldest), `tail` (next free), `count`; per-entry `done` bit.
- FSM states: RUN and RECOVER. Reset → RUN.
- RUN → RECOVER on `resolve_valid & resolve_mispredict` with tag T live. RECOVER → RUN unconditionally after one cycle.
- `alloc_ready` = (state==RUN) & (count<DEPTH) & !(resolve_valid & resolve_mispredict). It is combinational from registered state plus the mispredict input.
- Alloc is accepted when `alloc_valid & alloc_ready`:
  - snapshot[tail] = `alloc_state` with same-cycle CDB updates applied
  - done[tail] = 0
  - tail += 1, mod DEPTH
- Correct resolve of T: done[T] = 1. On every RUN cycle where done[head] is set and count>0, the head entry retires: head += 1, done cleared. At most one retire per cycle.
- Mispredict on T:
  - register `recover_state` = snapshot[T] with same-cycle CDB updates applied
  - `squash_mask` has bits T through tail−1 set, circularly
  - tail = T; count = (T − head) mod DEPTH
  - the same-cycle retire is suppressed
- CDB update: every cycle, for each live entry and each valid lane k, set valid = 1 in snapshot[entry].lreg[`cdb_lreg[k]`] if its preg equals `cdb_preg[k]`. A non-matching preg leaves the entry unchanged.
- count update: +1 on accepted alloc, −1 on retire, both when both occur.
- In RECOVER: no alloc, and resolves are ignored because the pipeline is flushing. CDB updates continue.
- Resolve of a non-live tag is ignored.

## Timing
- Reset values: head = tail = 0, count = 0, done = 0, state RUN, `recover_valid` = 0, `recover_state` = 0, `squash_mask` = 0, `alloc_ready` = 1, `alloc_tag` = 0.
- Alloc: tag visible on `alloc_tag` in the accepting cycle; snapshot usable for recovery from the next cycle.
- Mispredict in cycle N → `recover_valid` = 1 in N+1 for exactly one cycle, `alloc_ready` = 0 in N and N+1.
- Full (count==DEPTH): `alloc_ready` = 0. A retire in that cycle does not reopen it until N+1.
- Wrap: head and tail wrap mod DEPTH. Full versus empty is distinguished by count only.
- Reset asserted mid-recovery clears everything immediately, including a pending `recover_valid`.

## Test plan
- Reset, then 4 allocs with distinct states S0–S3 → tags 0,1,2,3; count = 4; `alloc_ready` = 0 after the 4th.
- Correct resolve of tags 1 then 0 → count 4→4→3→2 over the following cycles; head = 2.
- From 4 live (head = 0), mispredict tag 1 → next cycle `recover_valid` = 1, `recover_state` = S1, `squash_mask` = 4'b1110, count = 1, tail = 1.
- Alloc S0 with lreg5 = {0, p40}, then CDB lane2 (lreg5, p40) → mispredict tag 0 yields lreg5 = {1, p40}. CDB with (lreg5, p41) leaves valid = 0.
- Mispredict and alloc_valid in the same cycle → alloc not accepted; `alloc_ready` = 0 for 2 cycles; allocs after that wrap (tail 3→0).
- Reset low during the RECOVER cycle → `recover_valid` drops asynchronously; count = 0.
